gcd_arb: RTL and testbench

GCD_ARB -- requirements
Module: gcd_arb

---
 rtl/gcd_arb.sv | 189 ++++++++++++++++++
 tb/tb_gcd_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arb.sv
// ---------------------------------------------------------------------------
// gcd_arb
// Round-robin arbiter that shares one external GCD engine among NUM_REQ
// requesters. One job is in flight at a time: IDLE accepts a request, BUSY
// drives the engine until it reports done (or a timeout expires), and RESP
// holds the result for the owning requester until it is acknowledged.
// Jobs with a zero operand skip the engine and respond with A|B.
//
// Ports
//   clk_i             clock, all state on rising edge
//   reset_i           synchronous active-high reset
//   req_valid_i       per-requester request valid
//   req_a_i/req_b_i   packed operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o       one-hot grant, only in IDLE (combinational on req_valid_i)
//   resp_valid_o      one-hot response valid for the job owner
//   resp_ready_i      per-requester response ready
//   resp_data_o       shared result bus
//   resp_err_o        1 = engine timed out, resp_data_o is 0
//   eng_operand_a_o/b engine operands (latched job operands)
//   eng_enable_o      engine level enable, high throughout BUSY
//   eng_gcd_i         engine result
//   eng_done_i        engine completion flag
//   busy_o            high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module gcd_arb #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          resp_err_o,
    output logic [DATA_WIDTH-1:0]         eng_operand_a_o,
    output logic [DATA_WIDTH-1:0]         eng_operand_b_o,
    output logic                          eng_enable_o,
    input  logic [DATA_WIDTH-1:0]         eng_gcd_i,
    input  logic                          eng_done_i,
    output logic                          busy_o
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                 state_q;
    logic [IDW-1:0]         last_grant_q;
    logic [IDW-1:0]         id_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   err_q;
    logic                   eng_en_q;
    logic                   busy_q;
    logic [NUM_REQ-1:0]     resp_valid_q;

    logic                   grant_vld_d;
    logic [IDW-1:0]         grant_id_d;
    logic [NUM_REQ-1:0]     grant_oh_d;
    logic [DATA_WIDTH-1:0]  grant_a_d;
    logic [DATA_WIDTH-1:0]  grant_b_d;
    logic                   accept_d;

    // Requester index visited at position 'off' of the round-robin scan.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] last,
                                                input int unsigned off);
        int unsigned s;
        s = (32'(last) + 32'd1 + off) % NUM_REQ;
        return IDW'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld_d && req_valid_i[rr_index(last_grant_q, i)]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = rr_index(last_grant_q, i);
            end
        end
    end

    assign grant_oh_d = to_onehot(grant_id_d);
    assign grant_a_d  = req_a_i[grant_id_d*DATA_WIDTH +: DATA_WIDTH];
    assign grant_b_d  = req_b_i[grant_id_d*DATA_WIDTH +: DATA_WIDTH];

    // Reset gates the grant so no ready is shown while reset is applied.
    assign accept_d    = (state_q == IDLE) && grant_vld_d && !reset_i;
    assign req_ready_o = accept_d ? grant_oh_d : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            id_q         <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            eng_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        a_q          <= grant_a_d;
                        b_q          <= grant_b_d;
                        id_q         <= grant_id_d;
                        last_grant_q <= grant_id_d;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        if (grant_a_d != '0 && grant_b_d != '0) begin
                            state_q  <= BUSY;
                            eng_en_q <= 1'b1;
                        end else begin
                            // gcd(x,0) = x and gcd(0,0) = 0, so A|B covers all cases.
                            state_q      <= RESP;
                            data_q       <= grant_a_d | grant_b_d;
                            err_q        <= 1'b0;
                            resp_valid_q <= grant_oh_d;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // cnt_q == 0 is the first BUSY cycle: a done still high from
                    // the previous job is ignored there. Done beats timeout.
                    if (cnt_q != '0 && eng_done_i) begin
                        state_q      <= RESP;
                        data_q       <= eng_gcd_i;
                        err_q        <= 1'b0;
                        eng_en_q     <= 1'b0;
                        resp_valid_q <= to_onehot(id_q);
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= RESP;
                        data_q       <= '0;
                        err_q        <= 1'b1;
                        eng_en_q     <= 1'b0;
                        resp_valid_q <= to_onehot(id_q);
                    end
                end
                RESP: begin
                    if (resp_ready_i[id_q]) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        resp_valid_q <= '0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    eng_en_q     <= 1'b0;
                    resp_valid_q <= '0;
                end
            endcase
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = data_q;
    assign resp_err_o      = err_q;
    assign eng_operand_a_o = a_q;
    assign eng_operand_b_o = b_q;
    assign eng_enable_o    = eng_en_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_gcd_arb.sv
// ---------------------------------------------------------------------------
// tb_gcd_arb
// Directed bench for gcd_arb (DATA_WIDTH=8, NUM_REQ=4, TIMEOUT_CYCLES=255).
// A small engine model raises done after a programmable number of enable
// cycles and returns a programmed result. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_gcd_arb;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  resp_valid_o;
    logic [3:0]  resp_ready_i;
    logic [7:0]  resp_data_o;
    logic        resp_err_o;
    logic [7:0]  eng_a;
    logic [7:0]  eng_b;
    logic        eng_enable_o;
    logic [7:0]  eng_gcd_i;
    logic        eng_done_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    // Engine model: done in the (eng_lat+1)-th consecutive enable cycle.
    int       eng_cnt = 0;
    int       eng_lat = 1;
    logic [7:0] eng_result = 8'h00;
    bit       eng_never = 1'b0;
    bit       eng_stuck = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_enable_o) eng_cnt <= eng_cnt + 1;
        else              eng_cnt <= 0;
    end

    assign eng_done_i = eng_stuck || (eng_enable_o && !eng_never && eng_cnt == eng_lat);
    assign eng_gcd_i  = eng_result;

    gcd_arb #(
        .DATA_WIDTH    (8),
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .req_ready_o    (req_ready_o),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_data_o    (resp_data_o),
        .resp_err_o     (resp_err_o),
        .eng_operand_a_o(eng_a),
        .eng_operand_b_o(eng_b),
        .eng_enable_o   (eng_enable_o),
        .eng_gcd_i      (eng_gcd_i),
        .eng_done_i     (eng_done_i),
        .busy_o         (busy_o)
    );

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
        req_a_i[k*8 +: 8] = a;
        req_b_i[k*8 +: 8] = b;
        req_valid_i[k]    = 1'b1;
    endtask

    task automatic do_reset();
        reset_i      = 1'b1;
        req_valid_i  = '0;
        resp_ready_i = '0;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // Called in the accept cycle; returns falling edges until resp_valid_o
    // rises (cyc) and how many of them had eng_enable_o high (en).
    task automatic wait_resp(input int bound, output int cyc, output int en);
        cyc = 0;
        en  = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) req_valid_i = '0;
            if (eng_enable_o) en++;
            if (resp_valid_o != '0) break;
        end
    endtask

    task automatic test_reset();
        reset_i      = 1'b1;
        req_valid_i  = 4'hF;
        req_a_i      = 32'h0403_0201;
        req_b_i      = 32'h0807_0605;
        resp_ready_i = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (eng_enable_o !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", eng_enable_o); end
        checks++; if (resp_valid_o !== 4'b0000) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid_o); end
        checks++; if (resp_data_o !== 8'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", resp_data_o); end
        checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err_o); end
        checks++; if (eng_a !== 8'd0 || eng_b !== 8'd0) begin failures++; $display("FAIL reset_operands got=%0d,%0d exp=0,0", eng_a, eng_b); end
        reset_i     = 1'b0;
        req_valid_i = '0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc, en;
        do_reset();
        eng_lat    = 5;
        eng_result = 8'd6;
        set_req(0, 8'd48, 8'd18);
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready_o); end
        wait_resp(50, cyc, en);
        checks++; if (cyc !== 7) begin failures++; $display("FAIL single_latency got=%0d exp=7", cyc); end
        checks++; if (en !== 6) begin failures++; $display("FAIL single_enable_cycles got=%0d exp=6", en); end
        checks++; if (resp_valid_o !== 4'b0001) begin failures++; $display("FAIL single_resp_valid got=%b exp=0001", resp_valid_o); end
        checks++; if (resp_data_o !== 8'd6) begin failures++; $display("FAIL single_data got=%0d exp=6", resp_data_o); end
        checks++; if (resp_err_o !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", resp_err_o); end
        checks++; if (busy_o !== 1'b1 || eng_enable_o !== 1'b0) begin failures++; $display("FAIL single_resp_state busy=%b en=%b exp=1,0", busy_o, eng_enable_o); end
        checks++; if (eng_a !== 8'd48 || eng_b !== 8'd18) begin failures++; $display("FAIL single_operands got=%0d,%0d exp=48,18", eng_a, eng_b); end
        resp_ready_i = 4'b0001;
        @(negedge clk);
        resp_ready_i = '0;
        checks++; if (busy_o !== 1'b0 || resp_valid_o !== 4'b0000) begin failures++; $display("FAIL single_ack busy=%b rv=%b exp=0,0000", busy_o, resp_valid_o); end
        checks++; if (resp_data_o !== 8'd6) begin failures++; $display("FAIL single_data_hold got=%0d exp=6", resp_data_o); end
    endtask

    task automatic test_fairness();
        logic [3:0] got [5];
        logic [3:0] exp_order [5];
        int n, cyc;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        got       = '{default: 4'b0000};
        do_reset();
        eng_lat      = 1;
        eng_result   = 8'h11;
        resp_ready_i = 4'hF;
        for (int k = 0; k < 4; k++) set_req(k, 8'(k + 3), 8'(k + 5));
        n   = 0;
        cyc = 0;
        while (n < 5 && cyc < 200) begin
            #1;
            if (req_ready_o != '0) begin
                got[n] = req_ready_o;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp_order[i]) begin failures++; $display("FAIL fair_grant%0d got=%b exp=%b", i, got[i], exp_order[i]); end
        end
        req_valid_i  = '0;
        resp_ready_i = '0;
    endtask

    task automatic test_zero();
        int cyc, en;
        do_reset();
        set_req(2, 8'd0, 8'd35);
        #1;
        checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("FAIL zero_ready got=%b exp=0100", req_ready_o); end
        wait_resp(10, cyc, en);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
        checks++; if (en !== 0 || eng_enable_o !== 1'b0) begin failures++; $display("FAIL zero_enable got=%0d exp=0", en); end
        checks++; if (resp_valid_o !== 4'b0100) begin failures++; $display("FAIL zero_resp_valid got=%b exp=0100", resp_valid_o); end
        checks++; if (resp_data_o !== 8'd35 || resp_err_o !== 1'b0) begin failures++; $display("FAIL zero_data got=%0d err=%b exp=35,0", resp_data_o, resp_err_o); end
        resp_ready_i = 4'b0100;
        @(negedge clk);
        resp_ready_i = '0;
        set_req(2, 8'd0, 8'd0);
        #1;
        checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("FAIL zero00_ready got=%b exp=0100", req_ready_o); end
        wait_resp(10, cyc, en);
        checks++; if (cyc !== 1 || en !== 0) begin failures++; $display("FAIL zero00_timing cyc=%0d en=%0d exp=1,0", cyc, en); end
        checks++; if (resp_data_o !== 8'd0 || resp_valid_o !== 4'b0100) begin failures++; $display("FAIL zero00_data got=%0d rv=%b exp=0,0100", resp_data_o, resp_valid_o); end
        resp_ready_i = 4'b0100;
        @(negedge clk);
        resp_ready_i = '0;
        set_req(2, 8'd12, 8'd0);
        #1;
        wait_resp(10, cyc, en);
        checks++; if (resp_data_o !== 8'd12 || en !== 0) begin failures++; $display("FAIL zeroB_data got=%0d en=%0d exp=12,0", resp_data_o, en); end
        resp_ready_i = 4'b0100;
        @(negedge clk);
        resp_ready_i = '0;
    endtask

    task automatic test_timeout();
        int cyc, en;
        do_reset();
        eng_never = 1'b1;
        set_req(1, 8'd9, 8'd6);
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL tmo_ready got=%b exp=0010", req_ready_o); end
        wait_resp(400, cyc, en);
        checks++; if (cyc !== 256 || en !== 255) begin failures++; $display("FAIL tmo_cycles cyc=%0d en=%0d exp=256,255", cyc, en); end
        checks++; if (resp_valid_o !== 4'b0010) begin failures++; $display("FAIL tmo_resp_valid got=%b exp=0010", resp_valid_o); end
        checks++; if (resp_err_o !== 1'b1 || resp_data_o !== 8'd0) begin failures++; $display("FAIL tmo_err err=%b data=%0d exp=1,0", resp_err_o, resp_data_o); end
        resp_ready_i = 4'b0010;
        @(negedge clk);
        resp_ready_i = '0;
        // Done lands in the last allowed BUSY cycle: must win over timeout.
        eng_never  = 1'b0;
        eng_lat    = 254;
        eng_result = 8'd3;
        set_req(1, 8'd9, 8'd6);
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL tmo2_ready got=%b exp=0010", req_ready_o); end
        wait_resp(400, cyc, en);
        checks++; if (cyc !== 256 || en !== 255) begin failures++; $display("FAIL tmo2_cycles cyc=%0d en=%0d exp=256,255", cyc, en); end
        checks++; if (resp_err_o !== 1'b0 || resp_data_o !== 8'd3) begin failures++; $display("FAIL tmo2_done_wins err=%b data=%0d exp=0,3", resp_err_o, resp_data_o); end
        resp_ready_i = 4'b0010;
        @(negedge clk);
        resp_ready_i = '0;
    endtask

    task automatic test_back_to_back();
        int cyc, en;
        do_reset();
        eng_stuck  = 1'b1;
        eng_result = 8'd6;
        set_req(0, 8'd48, 8'd18);
        #1;
        checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL stale_ready got=%b exp=0001", req_ready_o); end
        wait_resp(20, cyc, en);
        eng_stuck = 1'b0;
        checks++; if (cyc !== 3 || en !== 2) begin failures++; $display("FAIL stale_ignore cyc=%0d en=%0d exp=3,2", cyc, en); end
        checks++; if (resp_data_o !== 8'd6 || resp_valid_o !== 4'b0001) begin failures++; $display("FAIL stale_data got=%0d rv=%b exp=6,0001", resp_data_o, resp_valid_o); end
        set_req(0, 8'd48, 8'd18);
        set_req(3, 8'd5, 8'd10);
        for (int i = 0; i < 10; i++) begin
            resp_ready_i = (i < 5) ? 4'b0000 : 4'b1110;
            @(negedge clk);
            checks++; if (resp_valid_o !== 4'b0001) begin failures++; $display("FAIL bp_resp_valid%0d got=%b exp=0001", i, resp_valid_o); end
            checks++; if (resp_data_o !== 8'd6 || resp_err_o !== 1'b0) begin failures++; $display("FAIL bp_data%0d got=%0d err=%b exp=6,0", i, resp_data_o, resp_err_o); end
            checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL bp_no_accept%0d got=%b exp=0000", i, req_ready_o); end
        end
        resp_ready_i = 4'b0001;
        @(negedge clk);
        resp_ready_i = '0;
        checks++; if (req_ready_o !== 4'b1000) begin failures++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready_o); end
        req_valid_i = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int cyc, en;
        do_reset();
        eng_lat    = 20;
        eng_result = 8'd6;
        set_req(1, 8'd77, 8'd33);
        #1;
        checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL mrst_ready got=%b exp=0010", req_ready_o); end
        @(negedge clk);
        req_valid_i = '0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (eng_enable_o !== 1'b1) begin failures++; $display("FAIL mrst_busy_en got=%b exp=1", eng_enable_o); end
        set_req(0, 8'd48, 8'd18);
        set_req(2, 8'd20, 8'd30);
        reset_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL mrst_ready_in_reset got=%b exp=0000", req_ready_o); end
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || eng_enable_o !== 1'b0) begin failures++; $display("FAIL mrst_state busy=%b en=%b exp=0,0", busy_o, eng_enable_o); end
        checks++; if (resp_valid_o !== 4'b0000 || resp_err_o !== 1'b0 || resp_data_o !== 8'd0) begin failures++; $display("FAIL mrst_resp rv=%b err=%b data=%0d exp=0000,0,0", resp_valid_o, resp_err_o, resp_data_o); end
        checks++; if (eng_a !== 8'd0 || eng_b !== 8'd0) begin failures++; $display("FAIL mrst_operands got=%0d,%0d exp=0,0", eng_a, eng_b); end
        checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL mrst_first_grant got=%b exp=0001", req_ready_o); end
        wait_resp(60, cyc, en);
        checks++; if (resp_valid_o !== 4'b0001) begin failures++; $display("FAIL mrst_owner got=%b exp=0001", resp_valid_o); end
        checks++; if (cyc !== 22 || resp_data_o !== 8'd6) begin failures++; $display("FAIL mrst_job cyc=%0d data=%0d exp=22,6", cyc, resp_data_o); end
        resp_ready_i = 4'b0001;
        @(negedge clk);
        resp_ready_i = '0;
    endtask

    initial begin
        reset_i      = 1'b1;
        req_valid_i  = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        resp_ready_i = '0;
        test_reset();
        test_single();
        test_fairness();
        test_zero();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
